// File: rtl/rtc_overlay_pkg.sv
// Shared colours, character codes and glyph geometry for the RTC text overlay.
package rtc_overlay_pkg;

  typedef logic [2:0] rgb_t;

  localparam rgb_t RGB_BLACK  = 3'b000;
  localparam rgb_t RGB_WHITE  = 3'b111;
  localparam rgb_t RGB_BLUE   = 3'b001;
  localparam rgb_t RGB_RED    = 3'b100;
  localparam rgb_t RGB_YELLOW = 3'b110;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_ALARM = 8'h06;

  localparam int GLYPH_W        = 16;
  localparam int GLYPH_H        = 32;
  localparam int COLS_PER_GROUP = 8;

  // Non-decimal nibbles render as a dash so corrupted BCD is visible on screen.
  function automatic logic [7:0] digit_char(input logic [3:0] n);
    return (n <= 4'd9) ? (CH_ZERO + {4'd0, n}) : CH_DASH;
  endfunction

endpackage

// File: rtl/font_rom.sv
// 8x16 character ROM, synchronous read; address is {char[6:0], row[3:0]}, bit 7 is the leftmost pixel.
module font_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  logic [127:0] glyph;
  logic [7:0]   data_d;
  logic [7:0]   data_q;

  always_comb begin
    glyph = '0;
    case (addr[10:4])
      7'h30: glyph = 128'h00007CC6_C6CEDEF6_E6C6C67C_00000000;
      7'h31: glyph = 128'h00001838_78181818_1818187E_00000000;
      7'h32: glyph = 128'h00007CC6_060C1830_60C0C6FE_00000000;
      7'h33: glyph = 128'h00007CC6_06063C06_0606C67C_00000000;
      7'h34: glyph = 128'h00000C1C_3C6CCCFE_0C0C0C1E_00000000;
      7'h35: glyph = 128'h0000FEC0_C0C0FC06_0606C67C_00000000;
      7'h36: glyph = 128'h00003860_C0C0FCC6_C6C6C67C_00000000;
      7'h37: glyph = 128'h0000FEC6_06060C18_30303030_00000000;
      7'h38: glyph = 128'h00007CC6_C6C67CC6_C6C6C67C_00000000;
      7'h39: glyph = 128'h00007CC6_C6C67E06_06060C78_00000000;
      7'h2F: glyph = 128'h00000000_02060C18_3060C080_00000000;
      7'h3A: glyph = 128'h00000000_18180000_00181800_00000000;
      7'h2D: glyph = 128'h00000000_000000FE_00000000_00000000;
      7'h06: glyph = 128'h00000000_183C7EFF_FF7E1818_3C000000;
      default: glyph = '0;
    endcase
    data_d = 8'(glyph >> {~addr[3:0], 3'b000});
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/rtc_text_overlay.sv
// Two-stage VGA text overlay for BCD date/time rows plus a blinking alarm glyph.
// Optional build macro CURSOR_BLINK_EN makes selected fields blink instead of staying yellow.
module rtc_text_overlay
  import rtc_overlay_pkg::*;
#(
  parameter int NUM_GROUPS = 3,
  parameter int CLK_HZ     = 25_000_000,
  parameter int BLINK_HZ   = 2,
  parameter int BASE_X     = 128,
  parameter int BASE_Y     = 64,
  parameter int ROW_PITCH  = 128,
  parameter int BOX_MARGIN = 4,
  parameter int SYM_X      = 512,
  parameter int SYM_Y      = 288
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [9:0]                pix_x,
  input  logic [9:0]                pix_y,
  input  logic                      video_on,
  input  logic [24*NUM_GROUPS-1:0]  digits,
  input  logic [3*NUM_GROUPS-1:0]   cursor_sel,
  input  logic                      alarm_on,
  output logic [2:0]                graph_rgb,
  output logic                      blink_phase
);

  localparam int GROUP_W = COLS_PER_GROUP * GLYPH_W;
  localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
  localparam int CNT_W   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  int         px, py, grp, fld;
  logic       in_grp, in_sym, in_box, cur_on;
  logic [5:0] x_half;
  logic [3:0] y_row, nib;
  logic [2:0] col;
  logic [6:0] char_code;
  rgb_t       fg_d;
  logic       glyph_d;

  logic [2:0] bit_q;
  rgb_t       fg_q;
  logic       glyph_q, box_q, von_q;
  rgb_t       rgb_q, rgb_d;
  logic [7:0] rom_data;

  assign px = int'(pix_x);
  assign py = int'(pix_y);

  always_comb begin
    blink_cnt_d   = blink_cnt_q + CNT_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == CNT_W'(HALF - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Stage 0: locate the pixel, pick the character and its foreground colour.
  always_comb begin
    in_grp = 1'b0;
    in_box = 1'b0;
    grp    = 0;
    x_half = 6'((px - SYM_X) >> 1);
    y_row  = 4'((py - SYM_Y) >> 1);
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (px >= BASE_X - BOX_MARGIN && px <= BASE_X + GROUP_W - 1 + BOX_MARGIN &&
          py >= BASE_Y + g*ROW_PITCH - BOX_MARGIN &&
          py <= BASE_Y + g*ROW_PITCH + GLYPH_H - 1 + BOX_MARGIN)
        in_box = 1'b1;
      if (px >= BASE_X && px < BASE_X + GROUP_W &&
          py >= BASE_Y + g*ROW_PITCH && py < BASE_Y + g*ROW_PITCH + GLYPH_H) begin
        in_grp = 1'b1;
        grp    = g;
        x_half = 6'((px - BASE_X) >> 1);
        y_row  = 4'((py - BASE_Y - g*ROW_PITCH) >> 1);
      end
    end
    in_sym = !in_grp && px >= SYM_X && px < SYM_X + GLYPH_W &&
             py >= SYM_Y && py < SYM_Y + GLYPH_H;

    col = x_half[5:3];
    fld = 3*grp + int'(col) / 3;
    nib = (col == 3'd0 || col == 3'd3 || col == 3'd6) ? 4'(digits >> (8*fld + 4))
                                                        : 4'(digits >> (8*fld));
    cur_on = 1'(cursor_sel >> fld);
`ifdef CURSOR_BLINK_EN
    cur_on = cur_on & blink_phase_q;
`endif

    char_code = 7'h00;
    fg_d      = RGB_WHITE;
    if (in_grp) begin
      if (col == 3'd2 || col == 3'd5) begin
        char_code = (grp == 0) ? 7'(CH_SLASH) : 7'(CH_COLON);
      end else begin
        char_code = 7'(digit_char(nib));
        if (nib > 4'd9)  fg_d = RGB_RED;
        else if (cur_on) fg_d = RGB_YELLOW;
      end
    end else if (in_sym) begin
      char_code = 7'(CH_ALARM);
      if (alarm_on && blink_phase_q) fg_d = RGB_RED;
    end
    glyph_d = in_grp | in_sym;
  end

  font_rom u_font_rom (
    .clk  (CLK),
    .addr ({char_code, y_row}),
    .data (rom_data)
  );

  // Stage 1: the ROM word for this pixel is now valid.
  always_comb begin
    rgb_d = RGB_BLACK;
    if (von_q) begin
      if (glyph_q && rom_data[3'd7 - bit_q]) rgb_d = fg_q;
      else if (box_q)                        rgb_d = RGB_BLUE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      bit_q         <= 3'd0;
      fg_q          <= RGB_BLACK;
      glyph_q       <= 1'b0;
      box_q         <= 1'b0;
      von_q         <= 1'b0;
      rgb_q         <= RGB_BLACK;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      bit_q         <= x_half[2:0];
      fg_q          <= fg_d;
      glyph_q       <= glyph_d;
      box_q         <= in_box;
      von_q         <= video_on;
      rgb_q         <= rgb_d;
    end
  end

  assign graph_rgb   = rgb_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_rtc_text_overlay.sv
// Self-checking bench for rtc_text_overlay: per-cycle golden model plus hand-computed pixel pins.
module tb_rtc_text_overlay;

  localparam int NG   = 3;
  localparam int HALF = 4;   // CLK_HZ=8, BLINK_HZ=1

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        video_on = 1'b0;
  logic [71:0] digits = '0;
  logic [8:0]  cursor_sel = '0;
  logic        alarm_on = 1'b0;
  logic [2:0]  graph_rgb;
  logic        blink_phase;

  rtc_text_overlay #(.NUM_GROUPS(NG), .CLK_HZ(8), .BLINK_HZ(1)) dut (
    .CLK(CLK), .RESET(RESET), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
    .digits(digits), .cursor_sel(cursor_sel), .alarm_on(alarm_on),
    .graph_rgb(graph_rgb), .blink_phase(blink_phase)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] font_row(input logic [7:0] code, input int row);
    logic [127:0] gl;
    case (code)
      8'h30: gl = 128'h00007CC6_C6CEDEF6_E6C6C67C_00000000;
      8'h31: gl = 128'h00001838_78181818_1818187E_00000000;
      8'h32: gl = 128'h00007CC6_060C1830_60C0C6FE_00000000;
      8'h33: gl = 128'h00007CC6_06063C06_0606C67C_00000000;
      8'h34: gl = 128'h00000C1C_3C6CCCFE_0C0C0C1E_00000000;
      8'h35: gl = 128'h0000FEC0_C0C0FC06_0606C67C_00000000;
      8'h36: gl = 128'h00003860_C0C0FCC6_C6C6C67C_00000000;
      8'h37: gl = 128'h0000FEC6_06060C18_30303030_00000000;
      8'h38: gl = 128'h00007CC6_C6C67CC6_C6C6C67C_00000000;
      8'h39: gl = 128'h00007CC6_C6C67E06_06060C78_00000000;
      8'h2F: gl = 128'h00000000_02060C18_3060C080_00000000;
      8'h3A: gl = 128'h00000000_18180000_00181800_00000000;
      8'h2D: gl = 128'h00000000_000000FE_00000000_00000000;
      8'h06: gl = 128'h00000000_183C7EFF_FF7E1818_3C000000;
      default: gl = '0;
    endcase
    return gl[127 - 8*row -: 8];
  endfunction

  // Colour a pixel must have, straight from the screen layout rules.
  function automatic logic [2:0] model_rgb(input int x, input int y, input logic von,
                                           input logic [71:0] dg, input logic [8:0] cs,
                                           input logic al, input logic ph);
    int gx, gy, c, f;
    logic [7:0] code, bits;
    logic [3:0] n;
    logic [2:0] fg;
    logic       cur_vis;
`ifdef CURSOR_BLINK_EN
    cur_vis = ph;
`else
    cur_vis = 1'b1;
`endif
    if (!von) return 3'b000;
    for (int g = 0; g < NG; g++) begin
      gx = x - 128;
      gy = y - (64 + 128*g);
      if (gx >= 0 && gx < 128 && gy >= 0 && gy < 32) begin
        c  = gx / 16;
        f  = 3*g + c/3;
        fg = 3'b111;
        if (c % 3 == 2) begin
          code = (g == 0) ? 8'h2F : 8'h3A;
        end else begin
          n = (c % 3 == 0) ? dg[8*f+4 +: 4] : dg[8*f +: 4];
          if (n > 4'd9) begin
            code = 8'h2D;
            fg   = 3'b100;
          end else begin
            code = 8'h30 + {4'h0, n};
            if (cs[f] && cur_vis) fg = 3'b110;
          end
        end
        bits = font_row(code, gy / 2);
        return bits[7 - (gx % 16) / 2] ? fg : 3'b001;
      end
    end
    if (x >= 512 && x < 528 && y >= 288 && y < 320) begin
      bits = font_row(8'h06, (y - 288) / 2);
      if (bits[7 - (x - 512) / 2]) return (al && ph) ? 3'b100 : 3'b111;
    end
    for (int g = 0; g < NG; g++)
      if (x >= 124 && x <= 259 && y >= 60 + 128*g && y <= 99 + 128*g) return 3'b001;
    return 3'b000;
  endfunction

  // Model: edges since reset give the blink phase; two pipeline slots give the output.
  int         m_n = 0;
  logic       m_phase;
  logic [2:0] m_pipe = '0, exp_rgb = '0;
  assign m_phase = ((m_n / HALF) % 2) == 1;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_n     <= 0;
      m_pipe  <= '0;
      exp_rgb <= '0;
    end else begin
      m_n     <= m_n + 1;
      exp_rgb <= m_pipe;
      m_pipe  <= model_rgb(int'(pix_x), int'(pix_y), video_on, digits, cursor_sel, alarm_on, m_phase);
    end
  end

  int         n_tests = 0, n_fail = 0;
  logic       chk_on = 1'b0, pin_en = 1'b0;
  logic [2:0] pin_exp = '0;
  string      pin_name = "";

  always @(negedge CLK) begin
    if (chk_on) begin
      n_tests++;
      if (graph_rgb !== exp_rgb) begin
        n_fail++;
        $display("FAIL rgb_model t=%0t: got %b expected %b", $time, graph_rgb, exp_rgb);
      end
      n_tests++;
      if (blink_phase !== m_phase) begin
        n_fail++;
        $display("FAIL blink_phase t=%0t: got %b expected %b", $time, blink_phase, m_phase);
      end
      if (pin_en) begin
        n_tests++;
        if (graph_rgb !== pin_exp) begin
          n_fail++;
          $display("FAIL pin %s t=%0t: got %b expected %b", pin_name, $time, graph_rgb, pin_exp);
        end
        n_tests++;
        if (exp_rgb !== pin_exp) begin
          n_fail++;
          $display("FAIL model_pin %s t=%0t: model %b expected %b", pin_name, $time, exp_rgb, pin_exp);
        end
      end
    end
  end

  task automatic drive(input int x, input int y, input logic von);
    @(posedge CLK);
    #1;
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = von;
  endtask

  task automatic pin(input string nm, input logic [2:0] e);
    pin_name = nm;
    pin_exp  = e;
    pin_en   = 1'b1;
    @(negedge CLK);
    #1 pin_en = 1'b0;
    $display("[TB] pin %s expected %b got %b", nm, e, graph_rgb);
  endtask

  task automatic pin_pixel(input string nm, input int x, input int y, input logic von,
                           input logic [2:0] e);
    drive(x, y, von);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    pin(nm, e);
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1,
                      input logic von_pattern, input logic rand_cursor);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        drive(x, y, von_pattern ? ((x + y) % 5 != 0) : 1'b1);
        if (rand_cursor) cursor_sel = 9'($urandom);
      end
    $display("[TB] scan x=%0d..%0d y=%0d..%0d done, %0d checks so far", x0, x1, y0, y1, n_tests);
  endtask

  task automatic hold(input int x, input int y, input int n);
    for (int i = 0; i < n; i++) drive(x, y, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // group0 = 3A / 07 / 21, group1 = 12 : 34 : 56, group2 = 99 : F0 : 45
    digits = {8'h45, 8'hF0, 8'h99, 8'h56, 8'h34, 8'h12, 8'h21, 8'h07, 8'h3A};
    repeat (3) @(posedge CLK);
    #1;
    RESET  = 1'b0;
    chk_on = 1'b1;
    pin("reset_rgb", 3'b000);

    pin_pixel("g1_digit1_on",  134, 196, 1'b1, 3'b111);
    pin_pixel("g1_digit1_off", 128, 196, 1'b1, 3'b001);
    pin_pixel("g1_colon",      166, 200, 1'b1, 3'b111);
    pin_pixel("g0_dash_red",   144,  78, 1'b1, 3'b100);
    pin_pixel("g0_tens3",      130,  68, 1'b1, 3'b111);
    pin_pixel("g0_slash",      172,  72, 1'b1, 3'b111);
    pin_pixel("box_tl_edge",   124, 188, 1'b1, 3'b001);
    pin_pixel("box_left_out",  123, 188, 1'b1, 3'b000);
    pin_pixel("box_top_out",   124, 187, 1'b1, 3'b000);
    pin_pixel("box_br_edge",   259, 227, 1'b1, 3'b001);
    pin_pixel("box_right_out", 260, 227, 1'b1, 3'b000);
    pin_pixel("box_bot_out",   259, 228, 1'b1, 3'b000);
    pin_pixel("sym_white",     512, 302, 1'b1, 3'b111);
    pin_pixel("sym_blank",     512, 288, 1'b1, 3'b000);
    pin_pixel("von_off",       134, 196, 1'b0, 3'b000);

    scan(122, 261, 186, 229, 1'b0, 1'b0);

    cursor_sel = 9'b000000011;
    scan(128, 255, 64, 95, 1'b0, 1'b0);
    hold(130, 68, 24);
    hold(196, 68, 12);

    alarm_on = 1'b1;
    scan(508, 531, 286, 321, 1'b0, 1'b0);
    hold(512, 302, 24);
    alarm_on = 1'b0;
    hold(512, 302, 12);

    scan(120, 263, 316, 355, 1'b1, 1'b1);

    // Asynchronous reset mid-line over a white glyph pixel.
    cursor_sel = '0;
    hold(134, 196, 5);
    @(posedge CLK);
    #3 RESET = 1'b1;
    pin("rst_async", 3'b000);
    @(posedge CLK);
    #1;
    pin("rst_hold", 3'b000);
    @(posedge CLK);
    #3 RESET = 1'b0;
    @(posedge CLK);
    #1;
    pin("rst_rel0", 3'b000);
    @(posedge CLK);
    #1;
    pin("rst_rel1", 3'b111);
    hold(134, 196, 12);

    @(posedge CLK);
    #1 chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_text_overlay.md
# rtc_text_overlay

Parametrised VGA text overlay for the RTC controller: renders `NUM_GROUPS` rows of three two-digit BCD fields as 16x32 glyphs, for example date, time and timer. Each row sits on a filled box, and an alarm symbol is drawn separately. It sits between the VGA sync generator (`pix_x`, `pix_y`, `video_on`) and the colour outputs. Added over the previous generation:
- configurable group count and layout;
- pipelined font lookup with fixed latency;
- invalid-BCD marking;
- a free-running blink timebase driving cursor and alarm blinking;
- reset.

## Interface
- `NUM_GROUPS`, 3 — number of field rows; group 0 uses `/` separators, the others `:`.
- `CLK_HZ`, 25_000_000 — pixel clock frequency.
- `BLINK_HZ`, 2 — blink frequency; half-period is `CLK_HZ/(2*BLINK_HZ)` cycles, which must be ≥1.
- `BASE_X`, 128 / `BASE_Y`, 64 — top-left pixel of group 0; `BASE_X` and `BASE_Y` must both be ≥ `BOX_MARGIN`.
- `ROW_PITCH`, 128 — vertical pixel distance between groups; must be ≥ 32 + 2·`BOX_MARGIN`.
- `BOX_MARGIN`, 4 — box extent beyond the glyph area, in pixels.
- `SYM_X`, 512 / `SYM_Y`, 288 — top-left pixel of the alarm symbol.

Ports:
- `CLK` in 1 — pixel clock.
- `RESET` in 1 — asynchronous, active-high.
- `pix_x`, `pix_y` in 10 each — scan coordinates.
- `video_on` in 1 — visible area.
- `digits` in 24·`NUM_GROUPS` — field f is `digits[8f+7:8f]`, with the tens digit in the high nibble; field 3g+k is column k of group g.
- `cursor_sel` in 3·`NUM_GROUPS` — bit f highlights field f.
- `alarm_on` in 1 — alarm active.
- `graph_rgb` out 3 — registered colour {R,G,B}.
- `blink_phase` out 1 — registered blink state.

## Operation
- Group g pixel area: x in [`BASE_X`, `BASE_X`+128), y in [`BASE_Y`+g·`ROW_PITCH`, +32).
- Character column c = (x−`BASE_X`)>>4. Columns 0,1 show field 3g; column 2 is the separator; columns 3,4 show field 3g+1; column 5 is the separator; columns 6,7 show field 3g+2.
- Glyph addressing: font row = y_rel[4:1], font bit = x_rel[3:1]; the 8x16 font is doubled in both axes.
- Digit code: nibble n ≤ 9 maps to 8'h30+n. Nibble > 9 maps to `-` (8'h2D) and is drawn red (100), overriding the cursor colour.
- Box g covers the group area extended by `BOX_MARGIN` on every side, inclusive.
- Alarm symbol: char 8'h06 in a 16x32 cell at (`SYM_X`,`SYM_Y`); always drawn.
- Colour priority per pixel:
  1. `video_on`=0 → 000.
  2. Glyph foreground bit set:
     - invalid digit → 100;
     - field's `cursor_sel` bit set → 110 (yellow);
     - alarm symbol with `alarm_on`=1 and `blink_phase`=1 → 100;
     - otherwise → 111.
  3. Inside a box → 001.
  4. Otherwise → 000.
- Multiple `cursor_sel` bits may be set at once; every selected field is highlighted independently.
- Blink timebase: counter 0..`CLK_HZ/(2*BLINK_HZ)`−1. On wrap, `blink_phase` toggles. The timebase runs regardless of `video_on`.

## Timing
- Fixed latency of 2 cycles: inputs sampled at edge t appear on `graph_rgb` after edge t+2. The sync generator delays `hsync`/`vsync` by 2 to match.
- Stage 0 (combinational from inputs):
  - char code, font row → `font_rom` address;
  - bit index, colour class, box flag, `video_on` → registered.
- Stage 1: `font_rom` data is valid; select the font bit; register `graph_rgb`.
- `digits`, `cursor_sel`, `alarm_on` and `blink_phase` are sampled in stage 0 with the pixel. A change mid-frame affects pixels from the next sample on, with no tearing inside a pipeline slot.
- Reset (asynchronous, any time):
  - `graph_rgb`=000, `blink_phase`=0, blink counter=0, all pipeline registers cleared (`video_on` register=0);
  - after release, the first 2 output cycles are 000.

## Configuration
- `CURSOR_BLINK_EN` defined: a selected field is drawn yellow only while `blink_phase`=1 and white while 0.
- `CURSOR_BLINK_EN` undefined: a selected field is steadily yellow.
- The alarm symbol blink is unaffected by the macro.

## Structure
- Package `rtc_overlay_pkg`:
  - colour constants (BLACK, WHITE, BLUE, RED, YELLOW);
  - char codes (`0`, `/`, `:`, `-`, alarm 8'h06);
  - glyph size constants (16, 32, 8 columns per group).
- Sub-module: the existing `font_rom` (synchronous read, 11-bit address {char[6:0], row[3:0]}, 8-bit data).
- The blink timebase is a small internal counter; no further sub-modules.

## Test plan
- `digits` group 1 = 24'h12_34_56, `cursor_sel`=0, scan group 1 → "12:34:56" in white on blue box; `graph_rgb` matches the font golden model exactly 2 cycles after each pixel.
- Field 0 = 8'h3A → tens digit `3` white, units `-` red; group 0 separators are `/`.
- `cursor_sel`=9'b000000011 → fields 0 and 1 yellow, field 2 white. With `CURSOR_BLINK_EN` and `CLK_HZ`=8, `BLINK_HZ`=1, the fields alternate yellow/white every 4 cycles.
- `alarm_on`=1, `CLK_HZ`=8, `BLINK_HZ`=1: symbol foreground toggles red/white every 4 cycles. With `alarm_on`=0 it is steady white.
- `video_on`=0 over a glyph → 000 two cycles later. Pixels 1 px outside a box → 000; pixels exactly on the box edge → 001.
- Assert `RESET` mid-line → `graph_rgb`=000 and `blink_phase`=0 immediately. After release, output is 000 for 2 cycles and the blink period restarts from 0.
